// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: blank/drive slot timing per digit with double-buffered value.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_display_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  output logic [3:0]            o_hex,
  output logic [DIGITS-1:0]     o_digit_en,
  output logic                  o_frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] act_q, act_d;
  logic [3:0]          hex_q, hex_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                done_q, done_d;
  logic [1:0]          arm_q;

`ifdef HEX_SCAN_LZB_EN
  logic                lead_zero;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    act_d   = act_q;
    // Nothing moves until the reset-release shifter has filled.
    if (arm_q[1]) begin
      if (i_load) pend_d = i_value;
      if (!i_enable) begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_d = S_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
            act_d   = pend_q;
          end
          S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_d = S_DRIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_DRIVE: begin
            if (cnt_q == SCAN_LAST) begin
              state_d = S_BLANK;
              cnt_d   = '0;
              if (idx_q == IDX_LAST) begin
                idx_d = '0;
                act_d = pend_q;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Outputs are decoded from next-state values so they can be registered without lag.
  always_comb begin
    hex_d  = act_d[4*idx_d +: 4];
    en_d   = '0;
    done_d = 1'b0;
    if (state_d == S_DRIVE) begin
      en_d   = DIGITS'(1) << idx_d;
      done_d = (idx_d == IDX_LAST) && (cnt_d == SCAN_LAST);
    end
`ifdef HEX_SCAN_LZB_EN
    lead_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if ((k >= 32'(idx_d)) && (act_d[4*k +: 4] != 4'h0)) lead_zero = 1'b0;
    end
    if ((idx_d != '0) && lead_zero) en_d = '0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arm_q   <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      hex_q   <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      arm_q   <= {arm_q[0], 1'b1};
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      hex_q   <= hex_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign o_hex        = hex_q;
  assign o_digit_en   = en_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner (DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2).
// Expectations follow HEX_SCAN_LZB_EN when it is defined for the build.
module tb_hex_display_scanner;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_load;
  logic [15:0] i_value;
  logic [3:0]  o_hex;
  logic [3:0]  o_digit_en;
  logic        o_frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef HEX_SCAN_LZB_EN
  localparam logic [3:0] MASK_0030 = 4'b0011;
  localparam logic [3:0] MASK_0000 = 4'b0001;
`else
  localparam logic [3:0] MASK_0030 = 4'b1111;
  localparam logic [3:0] MASK_0000 = 4'b1111;
`endif

  always #5 i_clk = ~i_clk;

  hex_display_scanner #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_value      (i_value),
    .o_hex        (o_hex),
    .o_digit_en   (o_digit_en),
    .o_frame_done (o_frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Walks ncyc cycles of a frame: per digit 2 blank cycles then 4 drive cycles.
  task automatic run_frame(input logic [15:0] val, input logic [3:0] mask, input int ncyc,
                           input int load_cyc, input logic [15:0] load_val);
    logic [3:0] exp_en;
    logic [3:0] exp_hex;
    for (int c = 0; c < ncyc; c++) begin
      int d  = c / 6;
      int ph = c % 6;
      if (c == load_cyc) begin
        i_load  = 1'b1;
        i_value = load_val;
      end
      step();
      i_load  = 1'b0;
      exp_en  = '0;
      if (ph >= 2 && mask[d]) exp_en[d] = 1'b1;
      exp_hex = 4'((val >> (4 * d)) & 16'hF);
      check_eq($sformatf("en[%0h c%0d]", val, c), 32'(o_digit_en), 32'(exp_en));
      check_eq($sformatf("hex[%0h c%0d]", val, c), 32'(o_hex), 32'(exp_hex));
      check_eq($sformatf("done[%0h c%0d]", val, c), 32'(o_frame_done), 32'(c == 23));
      check_eq($sformatf("onehot c%0d", c), 32'($onehot0(o_digit_en)), 32'd1);
    end
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    i_load   = 1'b0;
    i_value  = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_eq("rst_en", 32'(o_digit_en), 32'd0);
    check_eq("rst_hex", 32'(o_hex), 32'd0);
    check_eq("rst_done", 32'(o_frame_done), 32'd0);

    i_rst_n = 1'b1;
    repeat (3) step();
    i_load  = 1'b1;
    i_value = 16'h12AF;
    step();
    i_load   = 1'b0;
    i_enable = 1'b1;

    run_frame(16'h12AF, 4'hF, 24, -1, 16'h0);
    run_frame(16'h12AF, 4'hF, 24, 10, 16'h5555);   // mid-frame load
    run_frame(16'h5555, 4'hF, 24, 0, 16'h1234);    // load on wrap edge
    run_frame(16'h1234, 4'hF, 24, -1, 16'h0);

    // Drop enable during DRIVE of digit 2.
    run_frame(16'h1234, 4'hF, 15, -1, 16'h0);
    i_enable = 1'b0;
    step();
    check_eq("dis_en", 32'(o_digit_en), 32'd0);
    check_eq("dis_done", 32'(o_frame_done), 32'd0);
    step();
    check_eq("idle_en", 32'(o_digit_en), 32'd0);
    i_enable = 1'b1;
    run_frame(16'h1234, 4'hF, 24, -1, 16'h0);

    // Load while idle, then re-enable.
    i_enable = 1'b0;
    step();
    check_eq("idle2_en", 32'(o_digit_en), 32'd0);
    i_load  = 1'b1;
    i_value = 16'h0030;
    step();
    i_load   = 1'b0;
    i_enable = 1'b1;
    run_frame(16'h0030, MASK_0030, 24, -1, 16'h0);

    // Asynchronous reset while digit 1 is driven.
    run_frame(16'h0030, MASK_0030, 9, -1, 16'h0);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("arst_en", 32'(o_digit_en), 32'd0);
    check_eq("arst_hex", 32'(o_hex), 32'd0);
    check_eq("arst_done", 32'(o_frame_done), 32'd0);
    i_enable = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) step();
    check_eq("post_rst_en", 32'(o_digit_en), 32'd0);
    i_enable = 1'b1;
    run_frame(16'h0000, MASK_0000, 24, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
